mac4_accumulator: RTL

Sequential multiply-accumulate stage placed directly downstream of the 4x4 unsigned array multiplier. It accepts a burst of N_TERMS operand pairs over a valid/ready handshake and feeds each pair through the combinational 4x4 multiplier. It sums the 8-bit products into a wide accumulator and presents the dot-product result on an output valid/ready handshake. Typical uses are lab FIR taps and vector dot products.

---
 rtl/mac4_pkg.sv | 7 +
 rtl/mult4x4_comb.sv | 17 +
 rtl/mac4_accumulator.sv | 119 +++++++++++
 3 files changed

// File: rtl/mac4_pkg.sv
// mac4_pkg: shared state type and operand/product widths for the mac4 slice.
package mac4_pkg;
  localparam int OPND_W = 4;
  localparam int PROD_W = 8;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/mult4x4_comb.sv
// mult4x4_comb: purely combinational 4x4 unsigned shift-and-add multiplier.
module mult4x4_comb
  import mac4_pkg::*;
(
  input  logic [OPND_W-1:0] i_x,
  input  logic [OPND_W-1:0] i_y,
  output logic [PROD_W-1:0] o_p
);

  always_comb begin
    o_p = '0;
    for (int unsigned i = 0; i < OPND_W; i++) begin
      if (i_y[i]) o_p = o_p + (PROD_W'(i_x) << i);
    end
  end

endmodule

// File: rtl/mac4_accumulator.sv
// mac4_accumulator: bursts of N_TERMS 4x4 products summed into an ACC_W accumulator.
// Define MAC_SATURATE_EN to clamp on overflow instead of wrapping.
module mac4_accumulator
  import mac4_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OPND_W-1:0] x,
  input  logic [OPND_W-1:0] y,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overflow
);

  localparam logic [7:0] N_L = 8'(N_TERMS);

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic [PROD_W-1:0] r_prod_q;
  logic              r_prod_v;
  logic [ACC_W-1:0]  r_acc;
  logic              r_ovf;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;

  logic [PROD_W-1:0] w_prod;
  logic              w_accept;
  logic [ACC_W:0]    w_sum;
  logic [ACC_W-1:0]  w_acc_next;

  mult4x4_comb u_mult (
    .i_x (x),
    .i_y (y),
    .o_p (w_prod)
  );

  always_comb begin
    w_accept = in_valid && r_in_ready;
    w_sum    = {1'b0, r_acc} + (ACC_W+1)'(r_prod_q);
`ifdef MAC_SATURATE_EN
    w_acc_next = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
`else
    w_acc_next = w_sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_prod_q    <= '0;
      r_prod_v    <= 1'b0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= ACCUM;
            r_cnt      <= '0;
            r_prod_v   <= 1'b0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ACCUM: begin
          // in_ready is registered, so it drops on the edge taking the last beat
          if (w_accept) begin
            r_prod_q <= w_prod;
            r_prod_v <= 1'b1;
            r_cnt    <= r_cnt + 8'd1;
            if (r_cnt == N_L - 8'd1) r_in_ready <= 1'b0;
          end else begin
            r_prod_v <= 1'b0;
          end
          if (r_prod_v) begin
            r_acc <= w_acc_next;
            if (w_sum[ACC_W]) r_ovf <= 1'b1;
          end
          if (r_cnt == N_L && !r_prod_v) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = r_in_ready;
    acc_out   = r_acc;
    out_valid = r_out_valid;
    busy      = r_busy;
    overflow  = r_ovf;
  end

endmodule
